orientation_binner: RTL and testbench
=====================================

Name: orientation_binner

Overview:
- Sits directly downstream of the intensity-centroid stage.
- Consumes the truncated signed moments m10/m01 and their valid strobe.
- Produces a quantized keypoint orientation: a bin index 0..31 of 11.25 degrees each, equal to floor(atan2(m01,m10)/11.25deg).
- The rotated-BRIEF descriptor stage uses this index to select a steered sampling pattern.
- Fully pipelined, one sample per enabled cycle, no multipliers beyond constant shift-add.

Parameters:
- W_IN, 10, width of the signed moment inputs (two's complement).
- Q, 8, fractional bits of the tangent thresholds.
- T1..T7, 51/106/171/256/383/618/1287, round(tan(j*11.25deg)*2^Q) for j=1..7.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- ena  in  1  pipeline advance enable; all registers hold when low
- valid_in  in  1  moments valid strobe from the centroid stage
- m10_in  in  W_IN  signed x-moment
- m01_in  in  W_IN  signed y-moment
- angle_bin  out  5  unsigned orientation bin 0..31
- valid_out  out  1  angle_bin valid

Behaviour:
- Reset (async, rst=1): every pipeline register, angle_bin and valid_out are cleared to 0 immediately. This includes a reset asserted mid-stream: in-flight samples are discarded and no valid_out is produced for them after release.
- Pipeline: 3 register stages; latency is exactly 3 ena-high cycles from input sample to angle_bin/valid_out.
- valid rides a 3-deep shift register gated by the same ena.
- Data registers capture on every ena=1 cycle regardless of valid_in; validity is carried only by valid_out.
- ena=0: nothing moves; outputs hold their last values, including valid_out=1 if it was 1.
- Stage 1 (abs/quadrant), abs values are W_IN-bit unsigned (|-512|=512 fits):
  - (m10>0, m01>=0): base=0, num=|m01|, den=|m10|
  - (m10<=0, m01>0): base=8, num=|m10|, den=|m01|
  - (m10<0, m01<=0): base=16, num=|m01|, den=|m10|
  - (m10>=0, m01<0): base=24, num=|m10|, den=|m01|
  - (0,0): base=0, num=0, den=1, forcing bin 0.
  - Register base(5b), num, den.
- Stage 2 (compare): bit j = (num<<Q) >= den*Tj for j=1..7.
  - Products and comparisons are unsigned, at least W_IN+11 = 21 bits, with no truncation.
  - den*Tj is built as constant shift-add.
  - Equality counts as crossing the boundary, so an angle on a bin edge belongs to the upper bin.
  - Register the 7 bits and base.
- Stage 3 (encode): k = number of set compare bits (0..7; the bits are thermometer-coded because Tj is monotonic). angle_bin = base + k, registered; the range is 0..31 and never wraps.
- No backpressure from downstream. The consumer must sample valid_out on ena=1 cycles.

Test Plan:
- Reset: drive samples, assert rst for 1 cycle mid-stream -> angle_bin=0 and valid_out=0 immediately. No valid_out for any pre-reset sample after rst falls.
- Axes, ena=1: (m10,m01) = (100,0), (0,100), (-100,0), (0,-100), (0,0) back-to-back -> 3 cycles later, on consecutive cycles: bins 0, 8, 16, 24, 0, with valid_out high for 5 cycles.
- Diagonals: (100,100) -> 4; (-100,100) -> 12; (-512,-512) -> 20; (511,-512) -> 27.
- Threshold edge: (100,20) -> 1, since 5120>=5100. (100,19) -> 0, since 4864<5100. (1,511) -> 7, all 7 bits set.
- Stall: stream 4 valid samples, drop ena for 2 cycles after the 2nd -> outputs and valid_out freeze for exactly 2 cycles. All 4 bins emerge in order with correct values; no sample is lost or duplicated.
- Sparse valid: valid_in high 1 cycle in 5 with random moments -> valid_out pulses exactly 3 cycles after each input pulse. Each bin matches a reference model floor(atan2/11.25) with the edge-inclusive rule.

Source files
------------

// File: rtl/orientation_binner.sv
// Quantizes the (m10, m01) moment vector into one of 32 orientation bins of 11.25 degrees.
// Three-stage pipeline: quadrant fold, tangent-threshold compare, thermometer encode.
module orientation_binner #(
    parameter int unsigned W_IN = 10,
    parameter int unsigned Q    = 8,
    parameter int unsigned T1   = 51,
    parameter int unsigned T2   = 106,
    parameter int unsigned T3   = 171,
    parameter int unsigned T4   = 256,
    parameter int unsigned T5   = 383,
    parameter int unsigned T6   = 618,
    parameter int unsigned T7   = 1287
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   valid_in,
    input  logic signed [W_IN-1:0] m10_in,
    input  logic signed [W_IN-1:0] m01_in,
    output logic [4:0]             angle_bin,
    output logic                   valid_out
);

    // tan(78.75deg) < 8, so thresholds fit in Q+3 bits and products in W_IN+Q+3 bits
    localparam int unsigned TW = Q + 3;
    localparam int unsigned CW = W_IN + Q + 3;
    localparam logic [7*TW-1:0] T_PACK = {TW'(T7), TW'(T6), TW'(T5), TW'(T4),
                                          TW'(T3), TW'(T2), TW'(T1)};

    function automatic logic [CW-1:0] mul_const(input logic [W_IN-1:0] d,
                                                 input logic [TW-1:0]   t);
        logic [CW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            if (t[i]) acc = acc + (CW'(d) << i);
        end
        return acc;
    endfunction

    logic [W_IN-1:0] abs10, abs01;
    logic            x_pos, x_neg, y_pos, y_neg;

    logic [4:0]      s1_base_d, s1_base;
    logic [W_IN-1:0] s1_num_d, s1_num, s1_den_d, s1_den;
    logic [6:0]      s2_cmp_d, s2_cmp;
    logic [4:0]      s2_base;
    logic [2:0]      s3_k;
    logic [2:0]      valid_sr;

    assign abs10 = m10_in[W_IN-1] ? W_IN'(-m10_in) : W_IN'(m10_in);
    assign abs01 = m01_in[W_IN-1] ? W_IN'(-m01_in) : W_IN'(m01_in);
    assign x_neg = m10_in[W_IN-1];
    assign y_neg = m01_in[W_IN-1];
    assign x_pos = !x_neg && (|m10_in);
    assign y_pos = !y_neg && (|m01_in);

    // The origin matches no quadrant and keeps the defaults, yielding bin 0
    always_comb begin
        s1_base_d = '0;
        s1_num_d  = '0;
        s1_den_d  = W_IN'(1);
        if (x_pos && !y_neg) begin
            s1_base_d = 5'd0;
            s1_num_d  = abs01;
            s1_den_d  = abs10;
        end else if (!x_pos && y_pos) begin
            s1_base_d = 5'd8;
            s1_num_d  = abs10;
            s1_den_d  = abs01;
        end else if (x_neg && !y_pos) begin
            s1_base_d = 5'd16;
            s1_num_d  = abs01;
            s1_den_d  = abs10;
        end else if (!x_neg && y_neg) begin
            s1_base_d = 5'd24;
            s1_num_d  = abs10;
            s1_den_d  = abs01;
        end
    end

    always_comb begin
        s2_cmp_d = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            s2_cmp_d[j] = (CW'(s1_num) << Q) >= mul_const(s1_den, T_PACK[j*TW +: TW]);
        end
    end

    always_comb begin
        s3_k = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            s3_k = s3_k + 3'(s2_cmp[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_base   <= '0;
            s1_num    <= '0;
            s1_den    <= '0;
            s2_cmp    <= '0;
            s2_base   <= '0;
            angle_bin <= '0;
            valid_sr  <= '0;
        end else if (ena) begin
            s1_base   <= s1_base_d;
            s1_num    <= s1_num_d;
            s1_den    <= s1_den_d;
            s2_cmp    <= s2_cmp_d;
            s2_base   <= s1_base;
            angle_bin <= s2_base + 5'(s3_k);
            valid_sr  <= {valid_sr[1:0], valid_in};
        end
    end

    assign valid_out = valid_sr[2];

endmodule

// File: tb/tb_orientation_binner.sv
// Scoreboarded bench for orientation_binner: directed edge cases plus randomized sparse
// samples checked against a quadrant-rotation reference model.
module tb_orientation_binner;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              valid_in;
    logic signed [9:0] m10_in;
    logic signed [9:0] m01_in;
    logic [4:0]        angle_bin;
    logic              valid_out;

    typedef struct {
        int bin;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   tests     = 0;
    int   fails     = 0;
    int   adv_edges = 0;

    always #5 clk = ~clk;

    orientation_binner #(.W_IN(10), .Q(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .valid_in  (valid_in),
        .m10_in    (m10_in),
        .m01_in    (m01_in),
        .angle_bin (angle_bin),
        .valid_out (valid_out)
    );

    always @(posedge clk) if (ena && !rst) adv_edges <= adv_edges + 1;

    // Rotate by -90 degrees until the vector lies in [0,90), then count crossed tangent edges
    function automatic int ref_bin(input int x, input int y);
        int t[7] = '{51, 106, 171, 256, 383, 618, 1287};
        int base, k, tmp;
        if (x == 0 && y == 0) return 0;
        base = 0;
        while (!(x > 0 && y >= 0)) begin
            tmp  = x;
            x    = y;
            y    = -tmp;
            base = base + 8;
        end
        k = 0;
        for (int j = 0; j < 7; j++) if (y * 256 >= x * t[j]) k++;
        return base + k;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input int x, input int y, input int exp_bin);
        @(negedge clk);
        ena      = 1'b1;
        valid_in = v;
        m10_in   = 10'(x);
        m01_in   = 10'(y);
        if (v) q.push_back('{bin: exp_bin, edge_no: adv_edges + 3});
    endtask

    task automatic rand_step();
        int x, y;
        x = int'($urandom_range(0, 1023)) - 512;
        y = int'($urandom_range(0, 1023)) - 512;
        step(1'b1, x, y, ref_bin(x, y));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512, 0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ena      = 1'b0;
            valid_in = 1'b1;
            m10_in   = 10'($urandom);
            m01_in   = 10'($urandom);
        end
    endtask

    // Monitor: every advancing edge either delivers the head of the queue or nothing;
    // every non-advancing edge must leave the outputs untouched.
    initial begin
        exp_t       e;
        logic       adv, rst_e;
        logic [4:0] pb;
        logic       pv;
        pb = '0;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            adv   = ena && !rst;
            rst_e = rst;
            #1;
            if (adv) begin
                if (q.size() > 0 && q[0].edge_no == adv_edges) begin
                    e = q.pop_front();
                    check("valid_out", int'(valid_out), 1);
                    check("angle_bin", int'(angle_bin), e.bin);
                end else begin
                    check("idle_valid", int'(valid_out), 0);
                end
            end else if (!rst_e) begin
                check("hold_bin", int'(angle_bin), int'(pb));
                check("hold_valid", int'(valid_out), int'(pv));
            end
            pb = angle_bin;
            pv = valid_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        valid_in = 1'b0;
        m10_in   = '0;
        m01_in   = '0;
        repeat (3) @(negedge clk);
        check("reset_bin", int'(angle_bin), 0);
        check("reset_valid", int'(valid_out), 0);
        rst = 1'b0;

        // axes, back-to-back
        step(1'b1, 100, 0, 0);
        step(1'b1, 0, 100, 8);
        step(1'b1, -100, 0, 16);
        step(1'b1, 0, -100, 24);
        step(1'b1, 0, 0, 0);
        // diagonals
        step(1'b1, 100, 100, 4);
        step(1'b1, -100, 100, 12);
        step(1'b1, -512, -512, 20);
        step(1'b1, 511, -512, 27);
        // threshold edges
        step(1'b1, 100, 20, 1);
        step(1'b1, 100, 19, 0);
        step(1'b1, 1, 511, 7);
        idle(4);

        // stall after the second of four samples
        rand_step();
        rand_step();
        stall(2);
        rand_step();
        rand_step();
        idle(5);

        // mid-stream reset with valid non-zero output showing
        repeat (4) step(1'b1, -100, 100, 12);
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        q.delete();
        #1;
        check("midrst_bin", int'(angle_bin), 0);
        check("midrst_valid", int'(valid_out), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(6);

        // sparse valid: one pulse in five, occasional stall
        for (int n = 0; n < 40; n++) begin
            rand_step();
            idle(2);
            if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 2)));
            idle(2);
        end

        idle(6);
        check("drain_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
